// File: rtl/mem_sram_bridge.sv
// Memory-stage bridge from the pipeline M stage to an SRAM-like req/addr_ok/data_ok bus.
// Issues one bus access per M-stage load/store and stalls the pipeline until it completes.
module mem_sram_bridge #(
    parameter bit MAP_KSEG = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memenM,
    input  logic [3:0]  memwriteM,
    input  logic [1:0]  lsizeM,
    input  logic [31:0] aluoutM,
    input  logic [31:0] writedataM,
    input  logic        stall_in,
    output logic [31:0] readdataM,
    output logic        stallM,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    output logic [3:0]  data_wstrb,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata
);

    typedef enum logic [1:0] {
        StIdle,
        StAddr,
        StData,
        StDone
    } state_e;

    state_e      r_state;
    state_e      w_state_d;

    logic        r_wr;
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic [31:0] r_rdata;

    logic        w_store;
    logic [1:0]  w_st_size;
    logic [1:0]  w_size;
    logic [31:0] w_wdata;
    logic [31:0] w_addr;
    logic        w_issue;
    logic        w_data_done;

    assign w_store = |memwriteM;

    always_comb begin
        w_st_size = 2'd2;
        case (memwriteM)
            4'b1111:                            w_st_size = 2'd2;
            4'b0011, 4'b1100:                   w_st_size = 2'd1;
            4'b0001, 4'b0010, 4'b0100, 4'b1000: w_st_size = 2'd0;
            default:                            w_st_size = 2'd2;
        endcase
    end

    assign w_size = w_store ? w_st_size : lsizeM;

    // Replicate store data so the strobed lanes carry the low bytes of rt.
    always_comb begin
        w_wdata = writedataM;
        case (w_size)
            2'd0:    w_wdata = {4{writedataM[7:0]}};
            2'd1:    w_wdata = {2{writedataM[15:0]}};
            default: w_wdata = writedataM;
        endcase
    end

    // kseg0/kseg1 both alias physical memory from address zero.
    assign w_addr = (MAP_KSEG && (aluoutM[31:30] == 2'b10)) ? {3'b000, aluoutM[28:0]} : aluoutM;

    assign w_issue     = (r_state == StIdle) && memenM;
    assign w_data_done = (r_state == StData) && data_data_ok;

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle: if (memenM) w_state_d = data_addr_ok ? StData : StAddr;
            StAddr: if (data_addr_ok) w_state_d = StData;
            StData: if (data_data_ok) w_state_d = stall_in ? StDone : StIdle;
            StDone: if (!stall_in) w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= StIdle;
            r_wr    <= 1'b0;
            r_size  <= 2'd0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_wstrb <= 4'd0;
            r_rdata <= 32'd0;
        end else begin
            r_state <= w_state_d;
            if (w_issue) begin
                r_wr    <= w_store;
                r_size  <= w_size;
                r_addr  <= w_addr;
                r_wdata <= w_wdata;
                r_wstrb <= memwriteM;
            end
            if (w_data_done) begin
                r_rdata <= data_rdata;
            end
        end
    end

    // A request issued from IDLE uses live M inputs; once pending it replays the latches.
    always_comb begin
        data_req   = w_issue || (r_state == StAddr);
        data_wr    = w_issue ? w_store   : r_wr;
        data_size  = w_issue ? w_size    : r_size;
        data_addr  = w_issue ? w_addr    : r_addr;
        data_wdata = w_issue ? w_wdata   : r_wdata;
        data_wstrb = w_issue ? memwriteM : r_wstrb;
    end

    assign stallM    = memenM && (r_state != StDone) && !w_data_done;
    assign readdataM = w_data_done ? data_rdata : r_rdata;

endmodule

// File: tb/tb_mem_sram_bridge.sv
// Directed bench for mem_sram_bridge: hand-computed expectations checked with immediate asserts.
// A second instance with MAP_KSEG=0 shares the inputs to check pass-through addressing.
module tb_mem_sram_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        memenM;
    logic [3:0]  memwriteM;
    logic [1:0]  lsizeM;
    logic [31:0] aluoutM;
    logic [31:0] writedataM;
    logic        stall_in;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    logic [31:0] readdataM;
    logic        stallM;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_wstrb;

    logic [31:0] readdataM_0;
    logic        stallM_0;
    logic        data_req_0;
    logic        data_wr_0;
    logic [1:0]  data_size_0;
    logic [31:0] data_addr_0;
    logic [31:0] data_wdata_0;
    logic [3:0]  data_wstrb_0;

    int n_pass   = 0;
    int n_checks = 0;

    always #5 clk = ~clk;

    mem_sram_bridge #(.MAP_KSEG(1'b1)) dut (
        .clk          (clk),
        .rst          (rst),
        .memenM       (memenM),
        .memwriteM    (memwriteM),
        .lsizeM       (lsizeM),
        .aluoutM      (aluoutM),
        .writedataM   (writedataM),
        .stall_in     (stall_in),
        .readdataM    (readdataM),
        .stallM       (stallM),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_wstrb   (data_wstrb),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata)
    );

    mem_sram_bridge #(.MAP_KSEG(1'b0)) dut_nomap (
        .clk          (clk),
        .rst          (rst),
        .memenM       (memenM),
        .memwriteM    (memwriteM),
        .lsizeM       (lsizeM),
        .aluoutM      (aluoutM),
        .writedataM   (writedataM),
        .stall_in     (stall_in),
        .readdataM    (readdataM_0),
        .stallM       (stallM_0),
        .data_req     (data_req_0),
        .data_wr      (data_wr_0),
        .data_size    (data_size_0),
        .data_addr    (data_addr_0),
        .data_wdata   (data_wdata_0),
        .data_wstrb   (data_wstrb_0),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("check %s mismatch", tag);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic bus_quiet();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata   = 32'h0;
    endtask

    initial begin
        rst          = 1'b0;
        memenM       = 1'b0;
        memwriteM    = 4'b0000;
        lsizeM       = 2'd0;
        aluoutM      = 32'h0;
        writedataM   = 32'h0;
        stall_in     = 1'b0;
        bus_quiet();

        // Reset state
        #12;
        chk("rst_req",   {31'd0, data_req},   32'd0);
        chk("rst_stall", {31'd0, stallM},     32'd0);
        chk("rst_rdata", readdataM,           32'd0);
        chk("rst_addr",  data_addr,           32'd0);
        chk("rst_wr",    {31'd0, data_wr},    32'd0);
        chk("rst_size",  {30'd0, data_size},  32'd0);
        chk("rst_wdata", data_wdata,          32'd0);
        chk("rst_wstrb", {28'd0, data_wstrb}, 32'd0);
        tick();
        rst = 1'b1;
        tick();

        // 1: word load, addr_ok two cycles late, data_ok three cycles after it
        memenM = 1'b1; memwriteM = 4'b0000; lsizeM = 2'd2; aluoutM = 32'h8000_1000;
        settle();
        chk("t1_c0_req",   {31'd0, data_req},  32'd1);
        chk("t1_c0_addr",  data_addr,          32'h0000_1000);
        chk("t1_c0_size",  {30'd0, data_size}, 32'd2);
        chk("t1_c0_wr",    {31'd0, data_wr},   32'd0);
        chk("t1_c0_stall", {31'd0, stallM},    32'd1);
        tick();
        aluoutM = 32'h1234_5678;
        settle();
        chk("t1_c1_req",   {31'd0, data_req},  32'd1);
        chk("t1_c1_addr",  data_addr,          32'h0000_1000);
        chk("t1_c1_stall", {31'd0, stallM},    32'd1);
        tick();
        data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h1111_1111;
        settle();
        chk("t1_c2_req",   {31'd0, data_req},  32'd1);
        chk("t1_c2_stall", {31'd0, stallM},    32'd1);
        chk("t1_c2_rdata", readdataM,          32'd0);
        tick();
        bus_quiet();
        settle();
        chk("t1_c3_req",   {31'd0, data_req},  32'd0);
        chk("t1_c3_stall", {31'd0, stallM},    32'd1);
        tick();
        settle();
        chk("t1_c4_stall", {31'd0, stallM},    32'd1);
        tick();
        data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF;
        settle();
        chk("t1_c5_stall", {31'd0, stallM},    32'd0);
        chk("t1_c5_rdata", readdataM,          32'hDEAD_BEEF);
        tick();
        memenM = 1'b0; bus_quiet();
        settle();
        chk("t1_hold_rdata", readdataM,         32'hDEAD_BEEF);
        chk("t1_idle_req",   {31'd0, data_req}, 32'd0);
        tick();

        // 2: byte store, addr_ok same cycle, data_ok next cycle
        memenM = 1'b1; memwriteM = 4'b0010; writedataM = 32'h1234_5678; aluoutM = 32'h0000_2001;
        data_addr_ok = 1'b1;
        settle();
        chk("t2_req",   {31'd0, data_req},   32'd1);
        chk("t2_wr",    {31'd0, data_wr},    32'd1);
        chk("t2_size",  {30'd0, data_size},  32'd0);
        chk("t2_wdata", data_wdata,          32'h7878_7878);
        chk("t2_wstrb", {28'd0, data_wstrb}, 32'h2);
        chk("t2_addr",  data_addr,           32'h0000_2001);
        chk("t2_stall", {31'd0, stallM},     32'd1);
        tick();
        data_addr_ok = 1'b0; data_data_ok = 1'b1;
        settle();
        chk("t2_c1_req",   {31'd0, data_req}, 32'd0);
        chk("t2_c1_stall", {31'd0, stallM},   32'd0);
        tick();
        memenM = 1'b0; bus_quiet();
        tick();

        // 2b: halfword and word stores
        memenM = 1'b1; memwriteM = 4'b1100; writedataM = 32'h0000_ABCD; aluoutM = 32'h0000_2002;
        data_addr_ok = 1'b1;
        settle();
        chk("t2h_size",  {30'd0, data_size}, 32'd1);
        chk("t2h_wdata", data_wdata,         32'hABCD_ABCD);
        tick();
        data_addr_ok = 1'b0; data_data_ok = 1'b1;
        tick();
        memwriteM = 4'b1111; writedataM = 32'h1234_5678; aluoutM = 32'h0000_2004;
        data_addr_ok = 1'b1; data_data_ok = 1'b0;
        settle();
        chk("t2w_req",   {31'd0, data_req},  32'd1);
        chk("t2w_size",  {30'd0, data_size}, 32'd2);
        chk("t2w_wdata", data_wdata,         32'h1234_5678);
        tick();
        data_addr_ok = 1'b0; data_data_ok = 1'b1;
        tick();
        memenM = 1'b0; memwriteM = 4'b0000; bus_quiet();
        tick();

        // 3: kseg1 mapping vs pass-through, then kseg2 left alone
        memenM = 1'b1; lsizeM = 2'd2; aluoutM = 32'hBFC0_0004; data_addr_ok = 1'b1;
        settle();
        chk("t3_map",   data_addr,   32'h1FC0_0004);
        chk("t3_nomap", data_addr_0, 32'hBFC0_0004);
        tick();
        data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h0BAD_CAFE;
        settle();
        chk("t3_rdata", readdataM, 32'h0BAD_CAFE);
        tick();
        lsizeM = 2'd1; aluoutM = 32'hC000_0010; data_addr_ok = 1'b1; data_data_ok = 1'b0;
        settle();
        chk("t3_kseg2", data_addr,          32'hC000_0010);
        chk("t3_hsize", {30'd0, data_size}, 32'd1);
        tick();
        data_addr_ok = 1'b0; data_data_ok = 1'b1;
        tick();
        memenM = 1'b0; bus_quiet();
        tick();

        // 4: data_ok while the pipeline is frozen, then three more frozen cycles
        memenM = 1'b1; lsizeM = 2'd2; aluoutM = 32'h0000_3000; data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hCAFE_F00D; stall_in = 1'b1;
        settle();
        chk("t4_rdata", readdataM,        32'hCAFE_F00D);
        chk("t4_stall", {31'd0, stallM},  32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            bus_quiet();
            settle();
            chk("t4_done_req",   {31'd0, data_req}, 32'd0);
            chk("t4_done_stall", {31'd0, stallM},   32'd0);
            chk("t4_done_rdata", readdataM,         32'hCAFE_F00D);
        end
        tick();
        stall_in = 1'b0;
        settle();
        chk("t4_release_req", {31'd0, data_req}, 32'd0);
        tick();
        memenM = 1'b0;
        settle();
        chk("t4_idle_req",   {31'd0, data_req}, 32'd0);
        chk("t4_idle_rdata", readdataM,         32'hCAFE_F00D);
        tick();

        // 5: reset while waiting for data, then a stray data_ok
        memenM = 1'b1; aluoutM = 32'h0000_4000; data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        settle();
        memenM = 1'b0; rst = 1'b0;
        settle();
        chk("t5_req",   {31'd0, data_req}, 32'd0);
        chk("t5_stall", {31'd0, stallM},   32'd0);
        chk("t5_rdata", readdataM,         32'd0);
        tick();
        rst = 1'b1;
        tick();
        data_data_ok = 1'b1; data_rdata = 32'hBAAD_F00D;
        settle();
        chk("t5_stray_rdata", readdataM, 32'd0);
        tick();
        bus_quiet();
        settle();
        chk("t5_after_rdata", readdataM,         32'd0);
        chk("t5_after_req",   {31'd0, data_req}, 32'd0);
        tick();

        // 6: back-to-back loads
        memenM = 1'b1; lsizeM = 2'd2; aluoutM = 32'h0000_0100; data_addr_ok = 1'b1;
        settle();
        chk("t6_a_req",  {31'd0, data_req}, 32'd1);
        chk("t6_a_addr", data_addr,         32'h0000_0100);
        tick();
        data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h1111_2222;
        settle();
        chk("t6_a_gap",   {31'd0, data_req}, 32'd0);
        chk("t6_a_rdata", readdataM,         32'h1111_2222);
        chk("t6_a_stall", {31'd0, stallM},   32'd0);
        tick();
        aluoutM = 32'h0000_0204; data_addr_ok = 1'b1; data_data_ok = 1'b0; data_rdata = 32'h0;
        settle();
        chk("t6_b_req",   {31'd0, data_req}, 32'd1);
        chk("t6_b_addr",  data_addr,         32'h0000_0204);
        chk("t6_b_stall", {31'd0, stallM},   32'd1);
        tick();
        data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h3333_4444;
        settle();
        chk("t6_b_gap",   {31'd0, data_req}, 32'd0);
        chk("t6_b_rdata", readdataM,         32'h3333_4444);
        tick();
        memenM = 1'b0; bus_quiet();
        settle();
        chk("t6_end_req",   {31'd0, data_req}, 32'd0);
        chk("t6_end_rdata", readdataM,         32'h3333_4444);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
